// File: rtl/marquee_pkg.sv
// Shared types and constants for the marquee sequencer.
package marquee_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RIGHT  = 2'd1,
    S_LEFT   = 2'd2,
    S_BOUNCE = 2'd3
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [15:0] INIT_R = 16'h8000;
  localparam logic [15:0] INIT_L = 16'h0007;
  localparam logic [15:0] INIT_B = 16'h0001;

endpackage

// File: rtl/marquee_tick_gen.sv
// Free-running prescaler with fast/slow tick selection.
module marquee_tick_gen #(
  parameter int unsigned FAST_DIV = 23,
  parameter int unsigned SLOW_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic speed,
  output logic tick
);

  logic [SLOW_DIV-1:0] cnt_q, cnt_d;
  logic                fast_tick, slow_tick;

  always_comb cnt_d = cnt_q + SLOW_DIV'(1);

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Fast and slow ticks share one counter, so a speed change never restarts it.
  assign fast_tick = &cnt_q[FAST_DIV-1:0];
  assign slow_tick = &cnt_q;
  assign tick      = speed ? slow_tick : fast_tick;

endmodule

// File: rtl/marquee_sequencer.sv
// 16-LED marquee show: rotate-right dot, rotate-left bar, bouncing dot, repeat.
module marquee_sequencer
  import marquee_pkg::*;
#(
  parameter int unsigned FAST_DIV = 23,
  parameter int unsigned SLOW_DIV = 25,
  parameter int unsigned LEN      = 16,
  parameter int unsigned PASSES   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           speed,
  input  logic           start,
  input  logic           stop,
  output logic [LEN-1:0] led,
  output logic           step,
  output logic [1:0]     phase,
  output logic           busy
);

  localparam int unsigned P_R = LEN * PASSES;
  localparam int unsigned P_L = LEN * PASSES;
  localparam int unsigned P_B = 2 * (LEN - 1) * PASSES;
  localparam int unsigned CW  = $clog2(P_B) + 1;

  localparam logic [LEN-1:0] LED_R = LEN'(INIT_R);
  localparam logic [LEN-1:0] LED_L = LEN'(INIT_L);
  localparam logic [LEN-1:0] LED_B = LEN'(INIT_B);

  state_e         state_q, state_d;
  dir_e           dir_q, dir_d;
  logic [LEN-1:0] led_q, led_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           step_q, step_d;
  logic           tick, consumed, last_tick;
  logic [CW-1:0]  plen_m1;

  marquee_tick_gen #(
    .FAST_DIV(FAST_DIV),
    .SLOW_DIV(SLOW_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .speed(speed),
    .tick (tick)
  );

  always_comb begin
    case (state_q)
      S_RIGHT:  plen_m1 = CW'(P_R - 1);
      S_LEFT:   plen_m1 = CW'(P_L - 1);
      default:  plen_m1 = CW'(P_B - 1);
    endcase
  end

  assign consumed  = tick & en & (state_q != S_IDLE) & ~stop;
  assign last_tick = (cnt_q == plen_m1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    step_d  = consumed;
    if (stop) begin
      state_d = S_IDLE;
      led_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      led_d = '0;
      if (start) begin
        state_d = S_RIGHT;
        led_d   = LED_R;
        cnt_d   = '0;
      end
    end else if (consumed) begin
      cnt_d = cnt_q + CW'(1);
      case (state_q)
        S_RIGHT: begin
          if (last_tick) begin
            state_d = S_LEFT;
            led_d   = LED_L;
            cnt_d   = '0;
          end else begin
            led_d = {led_q[0], led_q[LEN-1:1]};
          end
        end
        S_LEFT: begin
          if (last_tick) begin
            state_d = S_BOUNCE;
            led_d   = LED_B;
            dir_d   = DIR_LEFT;
            cnt_d   = '0;
          end else begin
            led_d = {led_q[LEN-2:0], led_q[LEN-1]};
          end
        end
        default: begin
          if (last_tick) begin
            state_d = S_RIGHT;
            led_d   = LED_R;
            cnt_d   = '0;
          end else if (dir_q == DIR_LEFT) begin
            // Reaching an end flips direction and moves away in the same tick.
            if (led_q[LEN-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_LEFT;
      led_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign led   = led_q;
  assign step  = step_q;
  assign phase = state_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_marquee_sequencer.sv
// Self-checking bench for marquee_sequencer against a positional reference model.
module tb_marquee_sequencer;

  localparam int unsigned LEN = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b1;
  logic           speed = 1'b0;
  logic           start = 1'b1;
  logic           stop = 1'b0;
  logic [LEN-1:0] led;
  logic           step;
  logic [1:0]     phase;
  logic           busy;

  int checks = 0;
  int failures = 0;

  // Reference model: phase number, ticks consumed in phase, cycles since reset.
  int m_phase = 0;
  int m_k = 0;
  int m_cyc = 0;
  bit m_step = 0;

  marquee_sequencer #(
    .FAST_DIV(2),
    .SLOW_DIV(4),
    .LEN(16),
    .PASSES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .speed(speed),
    .start(start),
    .stop (stop),
    .led  (led),
    .step (step),
    .phase(phase),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic int phase_len(int p);
    return (p == 3) ? 2 * (LEN - 1) * 2 : LEN * 2;
  endfunction

  function automatic logic [31:0] model_led(int p, int k);
    int r, pos;
    case (p)
      1: return 32'h1 << (15 - (k % 16));
      2: begin
        r = k % 16;
        return ((32'h7 << r) | (32'h7 >> (16 - r))) & 32'hFFFF;
      end
      3: begin
        r   = k % 30;
        pos = (r <= 15) ? r : 30 - r;
        return 32'h1 << pos;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit tk;
    @(posedge clk);
    if (!rst) begin
      m_cyc = 0; m_phase = 0; m_k = 0; m_step = 0;
    end else begin
      tk     = speed ? (m_cyc % 16 == 15) : (m_cyc % 4 == 3);
      m_cyc  = (m_cyc + 1) % 16;
      m_step = 0;
      if (stop) begin
        m_phase = 0; m_k = 0;
      end else if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_k = 0; end
      end else if (tk && en) begin
        m_step = 1;
        m_k++;
        if (m_k == phase_len(m_phase)) begin
          m_phase = (m_phase == 3) ? 1 : m_phase + 1;
          m_k = 0;
        end
      end
    end
    #1;
    check("led", led, model_led(m_phase, m_k));
    check("step", step, m_step);
    check("phase", phase, m_phase);
    check("busy", busy, m_phase != 0);
  endtask

  task automatic run_ticks(input int n);
    int got = 0;
    int budget = n * 20 + 40;
    while (got < n && budget > 0) begin
      cyc();
      if (m_step) got++;
      budget--;
    end
    check("tick_budget", got, n);
  endtask

  task automatic run_until(input int p, input int k);
    int budget = 2000;
    while (!(m_phase == p && m_k == k) && budget > 0) begin
      cyc();
      budget--;
    end
    check("reach_budget", budget > 0, 1);
  endtask

  initial begin
    int gap;

    // 1. reset held with start asserted
    repeat (3) begin
      cyc();
      check("rst_led", led, 16'h0000);
      check("rst_phase", phase, 2'd0);
    end
    rst = 1'b1;
    cyc();
    check("start_phase", phase, 2'd1);
    check("start_led", led, 16'h8000);
    start = 1'b0;

    // 2. RIGHT phase, fast ticks
    run_ticks(1);
    check("r_first", led, 16'h4000);
    check("r_first_step", step, 1'b1);
    run_ticks(15);
    check("r_wrap", led, 16'h8000);
    run_ticks(16);
    check("r_end_phase", phase, 2'd2);
    check("r_end_led", led, 16'h0007);
    run_ticks(1);
    check("l_first", led, 16'h000E);

    // 3. LEFT to BOUNCE and back to RIGHT
    run_ticks(31);
    check("l_end_phase", phase, 2'd3);
    check("b_init", led, 16'h0001);
    run_ticks(15);
    check("b_top", led, 16'h8000);
    run_ticks(1);
    check("b_turn", led, 16'h4000);
    run_ticks(14);
    check("b_bottom", led, 16'h0001);
    run_ticks(30);
    check("b_end_phase", phase, 2'd1);
    check("b_end_led", led, 16'h8000);

    // 4. slow ticks, then enable freeze
    speed = 1'b1;
    run_ticks(1);
    check("slow_first", led, 16'h4000);
    repeat (2) begin
      gap = 0;
      do begin
        cyc();
        gap++;
      end while (!step && gap < 40);
      check("slow_gap", gap, 16);
    end
    speed = 1'b0;
    run_ticks(1);
    check("pre_freeze", led, 16'h0800);
    en = 1'b0;
    repeat (40) begin
      cyc();
      check("freeze_led", led, 16'h0800);
      check("freeze_step", step, 1'b0);
    end
    en = 1'b1;
    run_ticks(1);
    check("resume", led, 16'h0400);

    // random enable/speed soak inside the show
    repeat (250) begin
      en    = ($urandom_range(0, 9) < 7);
      speed = ($urandom_range(0, 7) == 0) ? ~speed : speed;
      cyc();
    end
    en = 1'b1;
    speed = 1'b0;

    // 5. stop coincident with a tick in LEFT
    run_until(2, 3);
    while (m_cyc % 4 != 3) cyc();
    stop = 1'b1;
    cyc();
    check("stop_phase", phase, 2'd0);
    check("stop_led", led, 16'h0000);
    check("stop_step", step, 1'b0);
    start = 1'b1;
    repeat (3) begin
      cyc();
      check("stop_start", phase, 2'd0);
    end
    stop = 1'b0;
    cyc();
    check("restart_phase", phase, 2'd1);
    check("restart_led", led, 16'h8000);
    start = 1'b0;

    // 6. reset mid-BOUNCE while moving right at 0100
    run_until(3, 22);
    check("b_mid", led, 16'h0100);
    rst = 1'b0;
    cyc();
    check("rst2_led", led, 16'h0000);
    check("rst2_phase", phase, 2'd0);
    rst = 1'b1;
    start = 1'b1;
    cyc();
    check("rst2_start", led, 16'h8000);
    start = 1'b0;
    run_ticks(31);
    check("rst2_still_r", phase, 2'd1);
    run_ticks(1);
    check("rst2_to_l", phase, 2'd2);

    // random control soak
    repeat (400) begin
      en    = ($urandom_range(0, 9) < 8);
      speed = ($urandom_range(0, 15) == 0) ? ~speed : speed;
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/marquee_sequencer.md
Name: marquee_sequencer

Overview:
- Sequences the 16-LED marquee datapath through a fixed show: rotate-right single dot, rotate-left 3-dot bar, bouncing dot, then repeat.
- Owns tick generation (fast/slow rate), the phase state machine, per-phase step counting and the LED shift register.
- Sits between the board switches/buttons (en, speed, start, stop) and the LED pins.

Parameters:
- FAST_DIV, 23, fast tick period is 2^FAST_DIV clk cycles.
- SLOW_DIV, 25, slow tick period is 2^SLOW_DIV clk cycles; must be greater than FAST_DIV.
- LEN, 16, LED count (led width).
- PASSES, 2, full loops per phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  1 = advance on ticks; 0 = freeze pattern and step count.
- speed  in  1  0 = fast tick, 1 = slow tick.
- start  in  1  level, sampled in IDLE; begins the show.
- stop  in  1  level; forces IDLE.
- led  out  LEN  LED pattern.
- step  out  1  one-cycle pulse on each consumed tick.
- phase  out  2  0 = IDLE, 1 = RIGHT, 2 = LEFT, 3 = BOUNCE.
- busy  out  1  1 when phase != IDLE.

Behaviour:
- Reset (rst == 0 at posedge clk):
  - prescaler = 0, state = IDLE, led = 0, step = 0, step_cnt = 0, dir = left.
  - Reset overrides every other input.
- Prescaler:
  - Free-running SLOW_DIV-bit counter; never gated by en, speed or stop.
  - fast_tick = 1 when the low FAST_DIV bits are all ones.
  - slow_tick = 1 when all SLOW_DIV bits are all ones.
  - tick = speed ? slow_tick : fast_tick. A speed change takes effect at the next tick; the prescaler is not restarted.
- Consumed tick: tick & en & state != IDLE & !stop. step = registered consumed tick, so it is high in the cycle led shows the new value.
- Phase lengths, in ticks: P_R = P_L = LEN*PASSES; P_B = 2*(LEN-1)*PASSES.
- step_cnt:
  - Increments on each consumed tick.
  - On the consumed tick where step_cnt == P_phase-1, the FSM moves to the next phase, loads that phase's initial pattern instead of shifting, and clears step_cnt.
- States and transitions:
  - IDLE: led = 0. If start & !stop, go to RIGHT next cycle with led = 16'h8000 (MSB only), step_cnt = 0. Ticks are ignored in IDLE.
  - RIGHT: each consumed tick rotates led right by 1 (bit0 wraps to bit LEN-1). At end of phase, go to LEFT, led = 16'h0007.
  - LEFT: each consumed tick rotates led left by 1 (bit LEN-1 wraps to bit0). At end of phase, go to BOUNCE, led = 16'h0001, dir = left.
  - BOUNCE: single dot shifts in dir.
    - Dot at bit LEN-1 with dir = left: this tick flips dir to right and shifts right.
    - Dot at bit0 with dir = right: this tick flips dir to left and shifts left.
    - At end of phase, go to RIGHT, led = 16'h8000.
- stop = 1 in any state: next cycle state = IDLE, led = 0, step_cnt = 0, no step pulse. stop wins over a simultaneous start or tick.
- en = 0: led, state, step_cnt and dir are held; ticks are dropped, not queued. start is still accepted from IDLE while en = 0.
- Widths:
  - step_cnt width = clog2(P_B) + 1.
  - Comparisons are unsigned.
  - No arithmetic on led; rotate and shift only.
- busy and phase are combinational decodes of the state register.

Decomposition:
- Shared package `marquee_pkg`:
  - state encoding localparams (S_IDLE = 0, S_RIGHT = 1, S_LEFT = 2, S_BOUNCE = 3);
  - initial patterns INIT_R = 16'h8000, INIT_L = 16'h0007, INIT_B = 16'h0001.
- One sub-module, `marquee_tick_gen`: prescaler plus the fast/slow select, parameterised by FAST_DIV and SLOW_DIV.
- FSM, step counter and LED register stay in the top level.

Test Plan:
- All tests use FAST_DIV = 2 and SLOW_DIV = 4, so a fast tick occurs every 4 cycles and a slow tick every 16.
1. Reset: rst = 0 for 3 cycles with start = 1 -> led = 0, phase = 0, busy = 0, step = 0 throughout. Release rst, start = 1 -> phase = 1 and led = 8000 next cycle.
2. RIGHT phase, en = 1, speed = 0:
   - first consumed tick -> led = 4000 with step = 1;
   - after 16 ticks -> led = 8000;
   - 32nd tick -> phase = 2, led = 0007;
   - next tick -> led = 000E.
3. LEFT to BOUNCE: run LEFT for 32 ticks -> phase = 3, led = 0001. Then:
   - after 15 more ticks -> led = 8000;
   - 16th -> led = 4000;
   - 30th -> led = 0001;
   - 60th BOUNCE tick -> phase = 1, led = 8000.
4. Speed and enable:
   - speed = 1 -> step exactly every 16 cycles.
   - en = 0 for 40 cycles mid-RIGHT with led = 0800 -> led stays 0800, no step, step_cnt unchanged.
   - en = 1 -> resumes at 0400 on the next tick.
5. stop: stop = 1 coincident with a tick in LEFT -> next cycle phase = 0, led = 0, no step. start = 1 with stop = 1 -> stays IDLE. stop = 0, start = 1 -> RIGHT, led = 8000.
6. Reset mid-BOUNCE with dir = right and led = 0100 -> IDLE, led = 0. A new start begins RIGHT at 8000 with step_cnt = 0, verified by the phase change exactly 32 ticks later.
